// File: rtl/tile_blitter_if.sv
// Request/handshake and tile-ROM port bundle for tile_blitter.
interface tile_blitter_if #(
  parameter int AW = 12,
  parameter int CW = 8
);
  logic          start;
  logic [AW-1:0] tile_addr;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  logic          flip_x;
  logic          key_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  modport master (output start, tile_addr, x_pos, y_pos, flip_x, key_en, rom_data,
                  input  busy, done, rom_addr);
  modport slave  (input  start, tile_addr, x_pos, y_pos, flip_x, key_en, rom_data,
                  output busy, done, rom_addr);
endinterface

// File: rtl/tile_blitter.sv
// Copies one TILE_W x TILE_H RGB tile from a byte-wide ROM onto a shared,
// tri-stated VGA pixel bus; one channel fetched every ROM_LAT cycles.
module tile_blitter #(
  parameter int          TILE_W  = 8,
  parameter int          TILE_H  = 8,
  parameter int          CW      = 8,
  parameter int          AW      = 12,
  parameter int          ROM_LAT = 2,
  parameter logic [23:0] KEY     = 24'hFF00FF
) (
  input  logic          clk,
  input  logic          resetn,
  tile_blitter_if.slave bus,
  output wire  [CW-1:0] vga_x,
  output wire  [CW-1:0] vga_y,
  output wire  [23:0]   vga_rgb,
  output wire           vga_we
);
  localparam int CWD = (TILE_W  > 1) ? $clog2(TILE_W)  : 1;
  localparam int RWD = (TILE_H  > 1) ? $clog2(TILE_H)  : 1;
  localparam int LWD = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LAST  = 2'd2;

  logic [1:0]     state;
  logic           busy_q, done_q;
  logic [AW-1:0]  rom_addr_q;
  logic [RWD-1:0] row;
  logic [CWD-1:0] col;
  logic [1:0]     ch;
  logic [LWD-1:0] lat_cnt;
  logic [AW-1:0]  base_q;
  logic [CW-1:0]  x_q, y_q;
  logic           flip_q, key_q;
  logic [7:0]     r_hold, g_hold;
  logic [CW-1:0]  vga_x_q, vga_y_q;
  logic [23:0]    vga_rgb_q;
  logic           vga_we_q;

  logic           last_col, last_row, cap;
  logic [RWD-1:0] nrow;
  logic [CWD-1:0] ncol;
  logic [23:0]    pix;

  // Byte address of channel ch of tile pixel (r, c); wraps modulo 2^AW.
  function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] base,
                                              input logic [RWD-1:0] r,
                                              input logic [CWD-1:0] c,
                                              input logic fl,
                                              input logic [1:0] chn);
    logic [31:0] src, off;
    src = fl ? (32'(TILE_W - 1) - 32'(c)) : 32'(c);
    off = 32'd3 * (32'(r) * 32'(TILE_W) + src) + 32'(chn);
    return base + off[AW-1:0];
  endfunction

  assign last_col = (col == CWD'(TILE_W - 1));
  assign last_row = (row == RWD'(TILE_H - 1));
  assign ncol     = last_col ? '0 : col + 1'b1;
  assign nrow     = last_col ? (last_row ? '0 : row + 1'b1) : row;
  assign cap      = (lat_cnt == LWD'(ROM_LAT - 1));
  assign pix      = {r_hold, g_hold, bus.rom_data};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      row        <= '0;
      col        <= '0;
      ch         <= 2'd0;
      lat_cnt    <= '0;
      base_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      flip_q     <= 1'b0;
      key_q      <= 1'b0;
      r_hold     <= '0;
      g_hold     <= '0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_rgb_q  <= '0;
      vga_we_q   <= 1'b0;
    end else begin
      vga_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          base_q     <= bus.tile_addr;
          x_q        <= bus.x_pos;
          y_q        <= bus.y_pos;
          flip_q     <= bus.flip_x;
          key_q      <= bus.key_en;
          row        <= '0;
          col        <= '0;
          ch         <= 2'd0;
          lat_cnt    <= '0;
          rom_addr_q <= byte_addr(bus.tile_addr, '0, '0, bus.flip_x, 2'd0);
          busy_q     <= 1'b1;
          state      <= S_FETCH;
        end
        S_FETCH: begin
          if (!cap) begin
            lat_cnt <= lat_cnt + 1'b1;
          end else begin
            lat_cnt <= '0;
            case (ch)
              2'd0: begin
                r_hold     <= bus.rom_data;
                ch         <= 2'd1;
                rom_addr_q <= byte_addr(base_q, row, col, flip_q, 2'd1);
              end
              2'd1: begin
                g_hold     <= bus.rom_data;
                ch         <= 2'd2;
                rom_addr_q <= byte_addr(base_q, row, col, flip_q, 2'd2);
              end
              default: begin
                // Keyed pixels leave the bus registers untouched, strobe stays low.
                if (!(key_q && pix == KEY)) begin
                  vga_x_q   <= x_q + CW'(col);
                  vga_y_q   <= y_q + CW'(row);
                  vga_rgb_q <= pix;
                  vga_we_q  <= 1'b1;
                end
                ch <= 2'd0;
                if (last_col && last_row) begin
                  done_q <= 1'b1;
                  state  <= S_LAST;
                end else begin
                  col        <= ncol;
                  row        <= nrow;
                  rom_addr_q <= byte_addr(base_q, nrow, ncol, flip_q, 2'd0);
                end
              end
            endcase
          end
        end
        S_LAST: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rom_addr = rom_addr_q;

  assign vga_x   = busy_q ? vga_x_q   : {CW{1'bz}};
  assign vga_y   = busy_q ? vga_y_q   : {CW{1'bz}};
  assign vga_rgb = busy_q ? vga_rgb_q : {24{1'bz}};
  assign vga_we  = busy_q ? vga_we_q  : 1'bz;
endmodule

// File: tb/tb_tile_blitter.sv
// Bench for tile_blitter: an 8x8/ROM_LAT=2 instance and a 2x2/ROM_LAT=1 instance
// checked cycle by cycle against a per-pixel reference model.
module tb_tile_blitter;
  localparam int          AW  = 12;
  localparam int          CW  = 8;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  tile_blitter_if #(.AW(AW), .CW(CW)) b0 ();
  tile_blitter_if #(.AW(AW), .CW(CW)) b1 ();

  wire [CW-1:0] vx0, vy0, vx1, vy1;
  wire [23:0]   rgb0, rgb1;
  wire          we0, we1;

  tile_blitter #(.TILE_W(8), .TILE_H(8), .CW(CW), .AW(AW), .ROM_LAT(2), .KEY(KEY)) u0 (
    .clk(clk), .resetn(resetn), .bus(b0),
    .vga_x(vx0), .vga_y(vy0), .vga_rgb(rgb0), .vga_we(we0));
  tile_blitter #(.TILE_W(2), .TILE_H(2), .CW(CW), .AW(AW), .ROM_LAT(1), .KEY(KEY)) u1 (
    .clk(clk), .resetn(resetn), .bus(b1),
    .vga_x(vx1), .vga_y(vy1), .vga_rgb(rgb1), .vga_we(we1));

  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  always @(posedge clk) b0.rom_data <= mem0[b0.rom_addr];
  assign b1.rom_data = mem1[b1.rom_addr];

  logic          sel;
  logic          start, flip, key;
  logic [AW-1:0] ta;
  logic [CW-1:0] xp, yp;

  assign b0.start = start && !sel;  assign b1.start = start && sel;
  assign b0.tile_addr = ta;  assign b1.tile_addr = ta;
  assign b0.x_pos = xp;      assign b1.x_pos = xp;
  assign b0.y_pos = yp;      assign b1.y_pos = yp;
  assign b0.flip_x = flip;   assign b1.flip_x = flip;
  assign b0.key_en = key;    assign b1.key_en = key;

  wire          busy_m = sel ? b1.busy : b0.busy;
  wire          done_m = sel ? b1.done : b0.done;
  wire [AW-1:0] radr_m = sel ? b1.rom_addr : b0.rom_addr;
  wire [CW-1:0] vx_m   = sel ? vx1 : vx0;
  wire [CW-1:0] vy_m   = sel ? vy1 : vy0;
  wire [23:0]   rgb_m  = sel ? rgb1 : rgb0;
  wire          we_m   = sel ? we1 : we0;

  int errs = 0;
  int checks = 0;

  // Model of the bus registers' held contents, per instance.
  logic [CW-1:0] hx [2];
  logic [CW-1:0] hy [2];
  logic [23:0]   hrgb [2];

  typedef struct {
    logic          s;
    logic [AW-1:0] ta;
    logic [CW-1:0] x, y;
    logic          f, k, poke, hold, ends;
    logic [CW-1:0] fx, fy, lx, ly;
    logic [23:0]   frgb, lrgb;
    int            npulse;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin hx[i] = '0; hy[i] = '0; hrgb[i] = '0; end
  endtask

  task automatic run_tile(input vec_t v);
    int W, H, L, N, slot, p, k, pulses, exp_pulses, row, col, src, a;
    int si;
    logic [AW-1:0] adr [192];
    logic [23:0]   px [64];
    logic [CW-1:0] pxx [64];
    logic [CW-1:0] pxy [64];
    logic          tr [64];
    W = v.s ? 2 : 8;  H = v.s ? 2 : 8;  L = v.s ? 1 : 2;  N = W * H;
    si = v.s ? 1 : 0;
    exp_pulses = 0;
    for (int q = 0; q < N; q++) begin
      row = q / W;  col = q % W;
      src = v.f ? (W - 1 - col) : col;
      for (int c = 0; c < 3; c++) begin
        a = (int'(v.ta) + 3 * (row * W + src) + c) % 4096;
        adr[3*q+c] = AW'(a);
      end
      px[q]  = v.s ? {mem1[adr[3*q]], mem1[adr[3*q+1]], mem1[adr[3*q+2]]}
                   : {mem0[adr[3*q]], mem0[adr[3*q+1]], mem0[adr[3*q+2]]};
      pxx[q] = CW'((int'(v.x) + col) % 256);
      pxy[q] = CW'((int'(v.y) + row) % 256);
      tr[q]  = v.k && (px[q] == KEY);
      if (!tr[q]) exp_pulses++;
    end
    pulses = 0;
    @(negedge clk);
    sel = v.s; ta = v.ta; xp = v.x; yp = v.y; flip = v.f; key = v.k; start = 1'b1;
    @(posedge clk);
    #1;
    if (!v.hold) start = 1'b0;
    for (int cyc = 0; cyc <= 3*L*N + 1; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (cyc <= 3*L*N) begin
        chk("busy", 32'(busy_m), 32'd1);
        chk("done", 32'(done_m), 32'(cyc == 3*L*N));
        k = cyc / L;
        if (k > 3*N - 1) k = 3*N - 1;
        chk("rom_addr", 32'(radr_m), 32'(adr[k]));
        slot = (cyc > 0) && (cyc % (3*L) == 0);
        if (slot) begin
          p = cyc / (3*L) - 1;
          if (!tr[p]) begin hx[si] = pxx[p]; hy[si] = pxy[p]; hrgb[si] = px[p]; end
          chk("we_slot", 32'(we_m), 32'(!tr[p]));
          if (v.ends && p == 0) begin
            chk("first_x", 32'(vx_m), 32'(v.fx));
            chk("first_y", 32'(vy_m), 32'(v.fy));
            chk("first_rgb", 32'(rgb_m), 32'(v.frgb));
          end
          if (v.ends && p == N-1) begin
            chk("last_x", 32'(vx_m), 32'(v.lx));
            chk("last_y", 32'(vy_m), 32'(v.ly));
            chk("last_rgb", 32'(rgb_m), 32'(v.lrgb));
          end
        end else begin
          chk("we_gap", 32'(we_m === 1'b1), 32'd0);
        end
        chk("vga_x", 32'(vx_m), 32'(hx[si]));
        chk("vga_y", 32'(vy_m), 32'(hy[si]));
        chk("vga_rgb", 32'(rgb_m), 32'(hrgb[si]));
        if (we_m === 1'b1) pulses++;
      end else begin
        chk("busy_end", 32'(busy_m), 32'd0);
        chk("done_end", 32'(done_m), 32'd0);
        chk("we_idle", 32'(we_m === 1'b1), 32'd0);
      end
    end
    chk("pulses_model", 32'(pulses), 32'(exp_pulses));
    if (v.npulse >= 0) chk("pulses_const", 32'(pulses), 32'(v.npulse));
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    sel = 1'b0; start = 1'b0; flip = 1'b0; key = 1'b0; ta = '0; xp = '0; yp = '0;
    for (int i = 0; i < 4096; i++) begin mem0[i] = 8'(i); mem1[i] = 8'(i); end
    model_reset();

    //        s  ta       x    y    f  k  poke hold ends fx   fy   lx   ly   frgb       lrgb       np
    tbl[0] = '{1'b0, 12'h000, 8'd10, 8'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               8'd10, 8'd20, 8'd17, 8'd27, 24'h000102, 24'hBDBEBF, 64};
    tbl[1] = '{1'b0, 12'h000, 8'd10, 8'd20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
               8'd10, 8'd20, 8'd17, 8'd27, 24'h151617, 24'hA8A9AA, 64};
    tbl[2] = '{1'b0, 12'h000, 8'd10, 8'd20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
               8'd10, 8'd20, 8'd17, 8'd27, 24'h000102, 24'hBDBEBF, 63};
    tbl[3] = '{1'b1, 12'h000, 8'd254, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               8'd254, 8'd255, 8'd255, 8'd0, 24'h000102, 24'h090A0B, 4};
    tbl[4] = '{1'b1, 12'hFFE, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               8'd0, 8'd0, 8'd1, 8'd1, 24'hFEFF00, 24'h070809, 4};
    // Start held across two tiles: the second is accepted right after one IDLE cycle.
    tbl[5] = '{1'b0, 12'h100, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               8'd0, 8'd0, 8'd0, 8'd0, 24'h0, 24'h0, 64};
    tbl[6] = '{1'b0, 12'h200, 8'd100, 8'd50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               8'd0, 8'd0, 8'd0, 8'd0, 24'h0, 24'h0, 64};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", 32'(b0.busy), 32'd0);
    chk("rst_done0", 32'(b0.done), 32'd0);
    chk("rst_addr0", 32'(b0.rom_addr), 32'd0);
    chk("rst_we0", 32'(we0 === 1'b1), 32'd0);
    chk("rst_busy1", 32'(b1.busy), 32'd0);
    chk("rst_addr1", 32'(b1.rom_addr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].poke) begin mem0[9] = 8'hFF; mem0[10] = 8'h00; mem0[11] = 8'hFF; end
      run_tile(tbl[i]);
      if (tbl[i].poke) begin mem0[9] = 8'd9; mem0[10] = 8'd10; mem0[11] = 8'd11; end
    end

    // Asynchronous reset in the middle of a tile
    @(negedge clk);
    sel = 1'b0; ta = 12'h040; xp = 8'd5; yp = 8'd6; flip = 1'b0; key = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(b0.busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(b0.busy), 32'd0);
    chk("arst_done", 32'(b0.done), 32'd0);
    chk("arst_addr", 32'(b0.rom_addr), 32'd0);
    chk("arst_we", 32'(we0 === 1'b1), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;

    // Randomised tiles over random ROM contents with keyed pixels sprinkled in
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    for (int n = 0; n < 8; n++) begin
      rv = tbl[0];
      rv.s = 1'($urandom);
      rv.ta = AW'($urandom);
      rv.x = CW'($urandom);
      rv.y = CW'($urandom);
      rv.f = 1'($urandom);
      rv.k = 1'($urandom);
      rv.poke = 1'b0; rv.hold = 1'b0; rv.ends = 1'b0; rv.npulse = -1;
      for (int j = 0; j < 2; j++) begin
        int a;
        a = (int'(rv.ta) + 3 * int'($urandom_range(rv.s ? 3 : 63, 0))) % 4096;
        if (rv.s) begin
          mem1[a] = 8'hFF; mem1[(a+1)%4096] = 8'h00; mem1[(a+2)%4096] = 8'hFF;
        end else begin
          mem0[a] = 8'hFF; mem0[(a+1)%4096] = 8'h00; mem0[(a+2)%4096] = 8'hFF;
        end
      end
      run_tile(rv);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected end before 2000000");
    $fatal(1);
  end
endmodule
